// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: configuration inputs and pulse outputs of the UART baud
// generator. The "master" side drives divisors/clears; the "slave" side is
// the generator itself.
interface uart_baud_gen_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
);
    logic                  enable;
    logic [DIV_WIDTH-1:0]  div;
    logic [FRAC_WIDTH-1:0] div_frac;
    logic [4:0]            osr;
    logic                  rx_clr;
    logic                  tx_clr;
    logic                  rx_tick;
    logic                  tx_tick;
    logic                  vote_edge;
    logic                  sample_edge;
    logic                  tx_edge;
    logic [4:0]            rx_phase;

    modport master (
        output enable, div, div_frac, osr, rx_clr, tx_clr,
        input  rx_tick, tx_tick, vote_edge, sample_edge, tx_edge, rx_phase
    );

    modport slave (
        input  enable, div, div_frac, osr, rx_clr, tx_clr,
        output rx_tick, tx_tick, vote_edge, sample_edge, tx_edge, rx_phase
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: two independent baud channels (index 0 = rx, 1 = tx), each
// with a divider counter producing oversample ticks and a phase counter that
// wraps every osr ticks. rx additionally produces three majority-vote pulses
// around mid-bit and a capture pulse one cycle after the last vote; tx
// produces a pulse on each bit boundary.
// Optional feature: define UART_BAUD_FRAC_EN to add a fractional divisor
// accumulator per channel (a carry stretches the next period by one pclk).
module uart_baud_gen #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
) (
    input  logic            pclk,
    input  logic            presetn,
    uart_baud_gen_if.slave  bus
);
    localparam int PW = DIV_WIDTH + 1;

    // Clamp the requested oversample ratio to the supported 4..16 range.
    function automatic logic [4:0] clamp_osr(input logic [4:0] o);
        logic [4:0] r;
        if (o < 5'd4) begin
            r = 5'd4;
        end else if (o > 5'd16) begin
            r = 5'd16;
        end else begin
            r = o;
        end
        return r;
    endfunction

    logic [1:0]                 clr_s;
    logic [4:0]                 osr_lim_s;
    logic [1:0][DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d, div_eff_s;
    logic [1:0][4:0]            phase_q, phase_d, osr_q, osr_d, osr_cur_s;
    logic [1:0]                 osr_vld_q, osr_vld_d, tick_q, tick_d, carry_s;
    logic [1:0][PW-1:0]         period_s;
    logic [4:0]                 mid_s;
    logic                       vote_q, vote_d, pend_q, pend_d;
    logic                       sample_q, sample_d, txe_q, txe_d;
`ifdef UART_BAUD_FRAC_EN
    logic [1:0][FRAC_WIDTH-1:0] acc_q, acc_d;
    logic [1:0]                 carry_q, carry_d;
    assign carry_s = carry_q;
`else
    assign carry_s = 2'b00;
`endif

    assign clr_s     = {bus.tx_clr, bus.rx_clr};
    assign osr_lim_s = clamp_osr(bus.osr);

    // Effective divisor, oversample ratio and period per channel; until a
    // value has been sampled (after reset or while div was 0) the live input is used.
    always_comb begin
        div_eff_s = '0;
        osr_cur_s = '0;
        period_s  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            div_eff_s[ch] = (div_q[ch] == '0) ? bus.div : div_q[ch];
            osr_cur_s[ch] = osr_vld_q[ch] ? osr_q[ch] : osr_lim_s;
            period_s[ch]  = {1'b0, div_eff_s[ch]} + PW'(carry_s[ch]);
        end
    end

    assign mid_s = osr_cur_s[0] >> 1;

    // Next state of both channels' divider, phase and accumulator.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        phase_d   = phase_q;
        osr_d     = osr_q;
        osr_vld_d = osr_vld_q;
        tick_d    = 2'b00;
`ifdef UART_BAUD_FRAC_EN
        acc_d     = acc_q;
        carry_d   = carry_q;
`endif
        for (int ch = 0; ch < 2; ch++) begin
            if (clr_s[ch]) begin
                cnt_d[ch]     = DIV_WIDTH'(1);
                div_d[ch]     = bus.div;
                phase_d[ch]   = 5'd0;
                osr_d[ch]     = osr_lim_s;
                osr_vld_d[ch] = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                acc_d[ch]     = '0;
                carry_d[ch]   = 1'b0;
`endif
            end else if (bus.enable && (div_eff_s[ch] != '0)) begin
                if ({1'b0, cnt_q[ch]} >= period_s[ch]) begin
                    cnt_d[ch]     = DIV_WIDTH'(1);
                    tick_d[ch]    = 1'b1;
                    div_d[ch]     = bus.div;
                    phase_d[ch]   = (phase_q[ch] == osr_cur_s[ch] - 5'd1) ?
                                    5'd0 : phase_q[ch] + 5'd1;
                    osr_d[ch]     = (phase_d[ch] == 5'd0) ? osr_lim_s : osr_cur_s[ch];
                    osr_vld_d[ch] = 1'b1;
`ifdef UART_BAUD_FRAC_EN
                    {carry_d[ch], acc_d[ch]} = {1'b0, acc_q[ch]} + {1'b0, bus.div_frac};
`endif
                end else begin
                    cnt_d[ch] = cnt_q[ch] + DIV_WIDTH'(1);
                end
            end else begin
                cnt_d[ch] = cnt_q[ch];
            end
        end
    end

    // Next state of the derived rx vote/sample and tx bit-boundary pulses.
    always_comb begin
        vote_d = tick_d[0] && (phase_d[0] >= mid_s - 5'd1) && (phase_d[0] <= mid_s + 5'd1);
        txe_d  = tick_d[1] && (phase_d[1] == 5'd0);
        if (clr_s[0]) begin
            pend_d   = 1'b0;
            sample_d = 1'b0;
        end else if (bus.enable) begin
            pend_d   = vote_d && (phase_d[0] == mid_s + 5'd1);
            sample_d = pend_q;
        end else begin
            pend_d   = pend_q;
            sample_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q     <= {DIV_WIDTH'(1), DIV_WIDTH'(1)};
            div_q     <= '0;
            phase_q   <= '0;
            osr_q     <= {5'd4, 5'd4};
            osr_vld_q <= 2'b00;
            tick_q    <= 2'b00;
            vote_q    <= 1'b0;
            pend_q    <= 1'b0;
            sample_q  <= 1'b0;
            txe_q     <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            acc_q     <= '0;
            carry_q   <= 2'b00;
`endif
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            osr_q     <= osr_d;
            osr_vld_q <= osr_vld_d;
            tick_q    <= tick_d;
            vote_q    <= vote_d;
            pend_q    <= pend_d;
            sample_q  <= sample_d;
            txe_q     <= txe_d;
`ifdef UART_BAUD_FRAC_EN
            acc_q     <= acc_d;
            carry_q   <= carry_d;
`endif
        end
    end

    assign bus.rx_tick     = tick_q[0];
    assign bus.tx_tick     = tick_q[1];
    assign bus.vote_edge   = vote_q;
    assign bus.sample_edge = sample_q;
    assign bus.tx_edge     = txe_q;
    assign bus.rx_phase    = phase_q[0];
endmodule
